// File: rtl/cadence_torque_cond_if.sv
// Sensor-side bundle between the raw cadence/torque inputs and the conditioning stage.
interface cadence_torque_cond_if;
   logic        cadence_raw;
   logic [11:0] torque;
   logic        torque_vld;
   logic [4:0]  cadence;
   logic        not_pedaling;
   logic [11:0] avg_torque;

   modport master (
      output cadence_raw, torque, torque_vld,
      input  cadence, not_pedaling, avg_torque
   );

   modport slave (
      input  cadence_raw, torque, torque_vld,
      output cadence, not_pedaling, avg_torque
   );
endinterface

// File: rtl/cadence_torque_cond.sv
// Cadence edge counting over a 2^WIN_W clock window plus exponential torque averaging.
// Optional build macro CADENCE_DEBOUNCE_EN inserts a 4-clock debounce filter on the cadence level.
module cadence_torque_cond #(
   parameter int WIN_W    = 22,
   parameter int AVG_SHFT = 5
) (
   input logic               clk,
   input logic               rst,
   cadence_torque_cond_if.slave bus
);
   localparam int ACC_W = 12 + AVG_SHFT;

   logic             sync1_r;
   logic             sync2_r;
   logic             sync3_r;
   logic             lvl_s;
   logic             cad_rise_s;
   logic             term_s;
   logic [WIN_W-1:0] win_cnt_r;
   logic [5:0]       edge_cnt_r;
   logic [6:0]       edge_sum_s;
   logic [4:0]       cadence_nxt_s;
   logic [4:0]       cadence_r;
   logic             not_ped_r;
   logic [ACC_W-1:0] acc_r;
   logic [ACC_W-1:0] acc_nxt_s;

   // Two-flop synchronizer for the asynchronous sensor, plus the edge-detect flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         sync3_r <= 1'b0;
      end else begin
         sync1_r <= bus.cadence_raw;
         sync2_r <= sync1_r;
         sync3_r <= lvl_s;
      end
   end

`ifdef CADENCE_DEBOUNCE_EN
   logic       filt_r;
   logic [1:0] stab_cnt_r;

   // Filtered level flips only after sync2 has disagreed with it for 4 consecutive clocks.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         filt_r     <= 1'b0;
         stab_cnt_r <= 2'd0;
      end else if (sync2_r != filt_r) begin
         if (stab_cnt_r == 2'd3) begin
            filt_r     <= sync2_r;
            stab_cnt_r <= 2'd0;
         end else begin
            stab_cnt_r <= stab_cnt_r + 2'd1;
         end
      end else begin
         stab_cnt_r <= 2'd0;
      end
   end

   assign lvl_s = filt_r;
`else
   assign lvl_s = sync2_r;
`endif

   assign cad_rise_s = lvl_s & ~sync3_r;
   assign term_s     = &win_cnt_r;

   // An edge arriving on the terminal cycle still belongs to the closing window.
   always_comb begin
      edge_sum_s = {1'b0, edge_cnt_r} + {6'd0, cad_rise_s};
      if (edge_sum_s > 7'd31) begin
         cadence_nxt_s = 5'd31;
      end else begin
         cadence_nxt_s = edge_sum_s[4:0];
      end
      if (not_ped_r) begin
         acc_nxt_s = {bus.torque, {AVG_SHFT{1'b0}}};
      end else begin
         acc_nxt_s = acc_r - (acc_r >> AVG_SHFT) + {{AVG_SHFT{1'b0}}, bus.torque};
      end
   end

   // Free-running window, saturating edge count and the latched cadence result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_cnt_r  <= {WIN_W{1'b0}};
         edge_cnt_r <= 6'd0;
         cadence_r  <= 5'd0;
         not_ped_r  <= 1'b1;
      end else begin
         win_cnt_r <= win_cnt_r + {{(WIN_W-1){1'b0}}, 1'b1};
         if (term_s) begin
            edge_cnt_r <= 6'd0;
            cadence_r  <= cadence_nxt_s;
            not_ped_r  <= (cadence_nxt_s < 5'd2);
         end else if (cad_rise_s && (edge_cnt_r != 6'd32)) begin
            edge_cnt_r <= edge_cnt_r + 6'd1;
         end else begin
            edge_cnt_r <= edge_cnt_r;
         end
      end
   end

   // Seeding while stopped lets the average track immediately once a sample arrives.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_r <= {ACC_W{1'b0}};
      end else if (bus.torque_vld) begin
         acc_r <= acc_nxt_s;
      end else begin
         acc_r <= acc_r;
      end
   end

   assign bus.cadence      = cadence_r;
   assign bus.not_pedaling = not_ped_r;
   assign bus.avg_torque   = acc_r[ACC_W-1:AVG_SHFT];
endmodule
